// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and hands each returned instruction, tagged with its PC,
// to decode over a valid/ready handshake. A redirect pulse replaces the PC and
// flushes whatever is in flight.
// Optional build macro: IFETCH_PERF_EN adds the fetch_count output.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        redirect,
`ifdef IFETCH_PERF_EN
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
`else
  input  logic [31:0] redirect_pc
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        load;
  logic        xfer;

  assign xfer      = instr_valid && instr_ready;
  // The fetch address is the PC register itself, so it only moves on a clock edge.
  assign imem_addr = pc_q;

  // Next-state, PC and discard-flag selection; redirect overrides every other event.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    load      = 1'b0;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        StIdle: begin
          state_d   = StReq;
          discard_d = 1'b0;
        end
        StReq: begin
          // A granted request is now stale; its response must be swallowed.
          if (imem_gnt) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end else begin
            state_d   = StReq;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_d   = StReq;
            discard_d = 1'b0;
          end else begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end
        StHold: begin
          state_d   = StReq;
          discard_d = 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_gnt) state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              state_d   = StReq;
              discard_d = 1'b0;
            end else begin
              load    = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (xfer) state_d = StReq;
        end
      endcase
    end
  end

  // State registers and registered outputs toward memory and decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      imem_req  <= (state_d == StReq);
      if (redirect) begin
        // Flushed slot shows a NOP so decode never sees the stale word.
        instr_valid <= 1'b0;
        instr       <= 32'h0000_0000;
      end else if (load) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        pc_out      <= pc_q;
      end else if (xfer) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  // Count delivered instructions; a transfer coinciding with a redirect is a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'h0000_0000;
    end else if (xfer && !redirect) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule
